z_core_div_unit: RTL and testbench
==================================

# z_core_div_unit

Multi-cycle integer divide sequencer for the RV32M DIV/DIVU/REM/REMU instructions. It sits beside the single-cycle ALU in the execute stage. The ALU control decoder steers M-extension divide ops here instead of to the ALU. The block accepts one operation at a time over a start/ready handshake, runs a restoring shift-subtract loop one quotient bit per cycle, applies sign fix-up, and returns the result with a one-cycle done pulse.

## Interface
- XLEN, 32, operand/result width; the iteration count equals XLEN.
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only on an edge where ready=1 and kill=0.
- funct3  in  3  operation: 100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes behave as DIVU.
- rs1  in  XLEN  dividend; sampled on the accept edge only.
- rs2  in  XLEN  divisor; sampled on the accept edge only.
- kill  in  1  pipeline flush; aborts any in-flight operation.
- ready  out  1  high when state is IDLE (combinational from state).
- busy  out  1  high in CALC or FIXUP.
- done  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  XLEN  quotient or remainder; holds its value until the next done.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- Reset values: state IDLE, done 0, result 0, busy 0, ready 1, iteration counter 0.
- Accept in IDLE (start=1, kill=0):
  - Latch op and the operand signs (signed ops only).
  - Load the absolute values of the operands (signed ops) or the raw operands (unsigned ops).
  - Clear the partial remainder and set the counter to XLEN-1.
- Special cases, decided on the accept edge: go straight to DONE with result loaded; CALC is bypassed.
  - Divisor zero: quotient = all ones (0xFFFFFFFF); remainder = rs1 unmodified. Applies to signed and unsigned ops.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- CALC, one quotient bit per cycle:
  - Shift {rem, dividend} left by 1.
  - If the trial value rem - divisor is non-negative (unsigned compare, XLEN+1-bit subtract), rem takes the difference and the quotient bit is 1; otherwise the quotient bit is 0.
  - Decrement the counter; the edge on which the counter reads 0 moves to FIXUP.
- FIXUP:
  - Quotient is negated if the signed op has differing operand signs.
  - Remainder is negated if the signed op has a negative dividend.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU) into result; go to DONE.
- DONE: done=1 for exactly one cycle; unconditional return to IDLE on the next edge.
- start while not ready: ignored; no queuing; the operands are not sampled.
- kill:
  - In any state, the next edge goes to IDLE.
  - A done pending in DONE still completes, because it is already visible in that cycle.
  - result is not updated by an aborted operation.
  - kill and start together in IDLE: kill wins; nothing is accepted.
- Reset mid-operation: immediate return to reset values; no done.

## Timing
- Normal path:
  - Accept edge E0.
  - CALC on edges E1..E32.
  - FIXUP on edge E33.
  - done high in the cycle after E33.
  - Latency XLEN+2 = 34 cycles from the start cycle to the done cycle.
- Special-case path: done high in the cycle after E0, a latency of 1.
- Back-to-back operation: ready rises the cycle after done; the earliest next accept is that edge. Throughput is one operation per 35 cycles (normal path).
- busy is low in IDLE and DONE.
- There are no combinational paths from inputs to done or result; the ready→start loop is registered.

## Test plan
- DIVU 100 / 7 → result 14; done exactly 34 cycles after the start cycle; ready low throughout.
- REM -7 / 2 → 0xFFFFFFFF (-1); DIV -7 / 2 → 0xFFFFFFFD (-3); REMU 0xFFFFFFF9 / 2 → 1.
- DIV 5 / 0 → 0xFFFFFFFF, done 1 cycle after accept. REM 5 / 0 → 5. DIV 0x80000000 / -1 → 0x80000000. REM of the same operands → 0.
- kill asserted 10 cycles into CALC → no done; ready back to 1 the next cycle; result unchanged. An immediate DIVU 9 / 3 → 3 at normal latency.
- start re-pulsed with new operands while busy → ignored; the original result (DIVU 100 / 7 = 14) is delivered unchanged. start+kill in IDLE → not accepted.
- rstn pulsed low mid-CALC → done 0, result 0, ready 1 immediately. After release, a fresh DIVU 1 / 1 → 1.

Source files
------------

// File: rtl/z_core_div_unit.sv
// Multi-cycle RV32M divide sequencer (DIV/DIVU/REM/REMU): restoring shift-subtract,
// one quotient bit per cycle, with sign fix-up and single-cycle divide-by-zero/overflow bypass.
module z_core_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  input  logic              kill,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem, dvd, dvs;
  logic              neg_q, neg_r, op_rem;

  logic signed [DATA_W-1:0] rs1_s, rs2_s;
  logic              is_signed, is_rem, rs1_neg, rs2_neg;
  logic              accept, div_zero, ovf, special;
  logic [DATA_W-1:0] special_res, fix_res;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W+1:0] trial;
  logic              q_bit;
  logic [DATA_W-1:0] rem_nxt;
  logic              unused_trial_bit;

  function automatic logic [DATA_W-1:0] negate_if(input logic [DATA_W-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] abs_if(input logic [DATA_W-1:0] v, input logic en);
    return negate_if(v, en & v[DATA_W-1]);
  endfunction

  assign rs1_s     = rs1;
  assign rs2_s     = rs2;
  assign is_signed = (funct3 == 3'b100) || (funct3 == 3'b110);
  assign is_rem    = (funct3 == 3'b110) || (funct3 == 3'b111);
  assign rs1_neg   = is_signed && (rs1_s < 0);
  assign rs2_neg   = is_signed && (rs2_s < 0);

  assign accept   = (state == IDLE) && start && !kill;
  assign div_zero = (rs2 == '0);
  assign ovf      = is_signed && (rs1 == MIN_NEG) && (rs2 == '1);
  assign special  = div_zero || ovf;

  // Divide-by-zero returns the raw dividend as remainder; overflow returns MIN_NEG / 0.
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = is_rem ? rs1 : '1;
    else
      special_res = is_rem ? '0 : MIN_NEG;
  end

  // One restoring step: the wide subtract's top bit is the borrow.
  assign rem_sh           = {rem, dvd[DATA_W-1]};
  assign trial            = {1'b0, rem_sh} - {2'b00, dvs};
  assign q_bit            = ~trial[DATA_W+1];
  assign rem_nxt          = q_bit ? trial[DATA_W-1:0] : rem_sh[DATA_W-1:0];
  assign unused_trial_bit = trial[DATA_W];

  assign fix_res = op_rem ? negate_if(rem, neg_r) : negate_if(dvd, neg_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= CNT_W'(DATA_W-1);
        if (special)
          result <= special_res;
      end else if ((state == CALC) && !kill && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if ((state == FIXUP) && !kill)
        result <= fix_res;
    end
  end

  // Datapath registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd    <= abs_if(rs1, is_signed);
      dvs    <= abs_if(rs2, is_signed);
      rem    <= '0;
      neg_q  <= rs1_neg ^ rs2_neg;
      neg_r  <= rs1_neg;
      op_rem <= is_rem;
    end else if (state == CALC) begin
      rem <= rem_nxt;
      dvd <= {dvd[DATA_W-2:0], q_bit};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : CALC;
      CALC:    if (kill) state_nxt = IDLE;
               else if (cnt == '0) state_nxt = FIXUP;
      FIXUP:   state_nxt = kill ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    busy  = (state == CALC) || (state == FIXUP);
    done  = (state == DONE);
  end

endmodule

// File: tb/tb_z_core_div_unit.sv
// Scoreboard bench for z_core_div_unit: directed ops push expected result and latency,
// a negedge monitor pops and compares on every done pulse.
module tb_z_core_div_unit;

  logic        clk = 1'b0;
  logic        rstn, start, kill;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        ready, busy, done;
  logic [31:0] result;

  typedef struct {
    string       nm;
    logic [31:0] res;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  z_core_div_unit #(.DATA_W(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .kill(kill), .ready(ready), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 result=%h expected no done", result);
      end else begin
        e = sb.pop_front();
        check32($sformatf("%s_result", e.nm), result, e.res);
        check32($sformatf("%s_latency", e.nm), 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=%b expected 1 within 100 cycles", ready);
    end
  endtask

  task automatic issue(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input bit push);
    wait_ready();
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    if (push) sb.push_back('{nm, exp, cyc, lat});
    @(posedge clk); #1;
    start = 1'b0; rs1 = 32'hDEAD_BEEF; rs2 = 32'h0BAD_F00D; funct3 = F_DIV;
  endtask

  task automatic wait_done(input bit chk_ready);
    int bad;
    int n;
    bad = 0;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      if (chk_ready && done !== 1'b1 && ready !== 1'b0) bad++;
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    if (chk_ready) check32("ready_low_while_busy", 32'(bad), 32'd0);
  endtask

  task automatic op(input string nm, input logic [2:0] f, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] exp, input int lat);
    issue(nm, f, a, b, exp, lat, 1'b1);
    wait_done(lat > 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; kill = 1'b0; funct3 = 3'b000; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_ready", 32'(ready), 32'd1);
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_done", 32'(done), 32'd0);
    check32("rst_result", result, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    op("divu_100_7",  F_DIVU, 32'd100,        32'd7,        32'd14,        34);
    op("remu_100_7",  F_REMU, 32'd100,        32'd7,        32'd2,         34);
    op("rem_m7_2",    F_REM,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF, 34);
    op("div_m7_2",    F_DIV,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 34);
    op("remu_fff9_2", F_REMU, 32'hFFFF_FFF9,  32'd2,        32'd1,         34);
    op("div_m100_7",  F_DIV,  32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 34);
    op("rem_m100_7",  F_REM,  32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFFE, 34);
    op("div_100_m7",  F_DIV,  32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);
    op("rem_100_m7",  F_REM,  32'd100,        32'hFFFF_FFF9, 32'd2,         34);
    op("div_m100_m7", F_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        34);
    op("divu_max_1",  F_DIVU, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 34);
    op("f000_as_divu", 3'b000, 32'd100,       32'd7,        32'd14,        34);

    op("rem_5_0",     F_REM,  32'd5,          32'd0,        32'd5,         1);
    op("rem_m7_0",    F_REM,  32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFF9, 1);
    op("remu_7_0",    F_REMU, 32'd7,          32'd0,        32'd7,         1);
    op("div_ovf",     F_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    op("rem_ovf",     F_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
    op("div_5_0",     F_DIV,  32'd5,          32'd0,        32'hFFFF_FFFF, 1);

    // Abort an operation ten cycles into CALC.
    issue("killed", F_DIVU, 32'd100, 32'd7, 32'd0, 0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check32("kill_busy_before", 32'(busy), 32'd1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check32("kill_ready_after", 32'(ready), 32'd1);
    check32("kill_result_kept", result, 32'hFFFF_FFFF);
    op("divu_9_3_after_kill", F_DIVU, 32'd9, 32'd3, 32'd3, 34);

    // A second start while busy must be ignored.
    issue("divu_100_7_repulse", F_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    funct3 = F_DIVU; rs1 = 32'd50; rs2 = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b1);

    // start together with kill in IDLE is not accepted.
    wait_ready();
    funct3 = F_DIVU; rs1 = 32'd8; rs2 = 32'd2; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check32("startkill_ready", 32'(ready), 32'd1);
    check32("startkill_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of CALC.
    issue("reset_victim", F_DIVU, 32'd100, 32'd7, 32'd0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check32("midrst_done", 32'(done), 32'd0);
    check32("midrst_result", result, 32'd0);
    check32("midrst_ready", 32'(ready), 32'd1);
    check32("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    op("divu_1_1_after_rst", F_DIVU, 32'd1, 32'd1, 32'd1, 34);

    repeat (40) @(posedge clk);
    #1;
    check32("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
